// File: rtl/tcb_lib_arbiter.sv
// Round-robin / fixed-priority arbiter sharing one TCB subordinate between MPN managers.
// Holds a stalled grant until its transfer completes and routes responses back after DLY cycles.
module tcb_lib_arbiter #(
  parameter int unsigned MPN = 2,
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned BEN = DAT/8,
  parameter int unsigned DLY = 1,
  parameter bit          RRB = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MPN-1:0]     sub_vld,
  input  logic [MPN-1:0]     sub_wen,
  input  logic [MPN*ADR-1:0] sub_adr,
  input  logic [MPN*BEN-1:0] sub_ben,
  input  logic [MPN*DAT-1:0] sub_wdt,
  output logic [MPN*DAT-1:0] sub_rdt,
  output logic [MPN-1:0]     sub_err,
  output logic [MPN-1:0]     sub_rdy,
  output logic               man_vld,
  output logic               man_wen,
  output logic [ADR-1:0]     man_adr,
  output logic [BEN-1:0]     man_ben,
  output logic [DAT-1:0]     man_wdt,
  input  logic [DAT-1:0]     man_rdt,
  input  logic               man_err,
  input  logic               man_rdy,
  output logic [MPN-1:0]     gnt
);

  localparam int unsigned IW = (MPN > 1) ? $clog2(MPN) : 1;
  localparam int unsigned EW = IW + 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] lix;
  logic          lck;
  logic [IW-1:0] sel;
  logic          trn;
  logic          rsp_vld;
  logic [IW-1:0] rsp_idx;

  logic [ADR-1:0] adr_a [MPN];
  logic [BEN-1:0] ben_a [MPN];
  logic [DAT-1:0] wdt_a [MPN];

  for (genvar g = 0; g < MPN; g++) begin : g_split
    assign adr_a[g] = sub_adr[g*ADR +: ADR];
    assign ben_a[g] = sub_ben[g*BEN +: BEN];
    assign wdt_a[g] = sub_wdt[g*DAT +: DAT];
  end

  always_comb begin : arb
    logic          found;
    logic [IW-1:0] cand;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    if (lck) begin
      sel = lix;
    end else if (RRB) begin
      for (int unsigned k = 1; k <= MPN; k++) begin
        cand = IW'((32'(ptr) + k) % MPN);
        if (!found && sub_vld[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end else begin
      for (int unsigned i = 0; i < MPN; i++) begin
        cand = IW'(i);
        if (!found && sub_vld[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  always_comb begin
    man_vld = lck ? sub_vld[lix] : |sub_vld;
    gnt     = man_vld ? (MPN'(1) << sel) : '0;
    sub_rdy = {MPN{man_rdy}} & gnt;
    trn     = man_vld & man_rdy;
    man_wen = sub_wen[sel];
    man_adr = adr_a[sel];
    man_ben = ben_a[sel];
    man_wdt = wdt_a[sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IW'(MPN - 1);
      lck <= 1'b0;
      lix <= '0;
    end else if (trn) begin
      ptr <= sel;
      lck <= 1'b0;
    end else if (man_vld) begin
      lck <= 1'b1;
      lix <= sel;
    end
  end

  // Response tracking: {valid, index} pairs shifted DLY stages, newest in the low slot.
  if (DLY == 0) begin : g_rsp0
    assign rsp_vld = trn;
    assign rsp_idx = sel;
  end else begin : g_rspn
    logic [DLY*EW-1:0] pipe;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe <= '0;
      end else begin
        if (DLY == 1) pipe <= {trn, sel};
        else          pipe <= {pipe[(DLY-1)*EW-1:0], trn, sel};
      end
    end
    assign rsp_vld = pipe[DLY*EW-1];
    assign rsp_idx = pipe[DLY*EW-2 -: IW];
  end

  always_comb begin
    sub_rdt = {MPN{man_rdt}};
    sub_err = '0;
    if (rsp_vld) sub_err[rsp_idx] = man_err;
  end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Bench for tcb_lib_arbiter: round-robin and fixed-priority instances checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_tcb_lib_arbiter;

  localparam int MPN = 2;
  localparam int ADR = 32;
  localparam int DAT = 32;
  localparam int BEN = 4;
  localparam int DLY = 1;

  logic clk = 1'b0;
  logic rst;
  logic [MPN-1:0]     sub_vld, sub_wen;
  logic [MPN*ADR-1:0] sub_adr;
  logic [MPN*BEN-1:0] sub_ben;
  logic [MPN*DAT-1:0] sub_wdt;
  logic [DAT-1:0]     man_rdt;
  logic               man_err, man_rdy;

  logic [MPN*DAT-1:0] rr_sub_rdt, fp_sub_rdt;
  logic [MPN-1:0]     rr_sub_err, fp_sub_err, rr_sub_rdy, fp_sub_rdy, rr_gnt, fp_gnt;
  logic               rr_man_vld, fp_man_vld, rr_man_wen, fp_man_wen;
  logic [ADR-1:0]     rr_man_adr, fp_man_adr;
  logic [BEN-1:0]     rr_man_ben, fp_man_ben;
  logic [DAT-1:0]     rr_man_wdt, fp_man_wdt;

  always #5 clk = ~clk;

  tcb_lib_arbiter #(.MPN(MPN), .ADR(ADR), .DAT(DAT), .BEN(BEN), .DLY(DLY), .RRB(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt),
    .sub_rdt(rr_sub_rdt), .sub_err(rr_sub_err), .sub_rdy(rr_sub_rdy),
    .man_vld(rr_man_vld), .man_wen(rr_man_wen), .man_adr(rr_man_adr), .man_ben(rr_man_ben),
    .man_wdt(rr_man_wdt), .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy),
    .gnt(rr_gnt)
  );

  tcb_lib_arbiter #(.MPN(MPN), .ADR(ADR), .DAT(DAT), .BEN(BEN), .DLY(DLY), .RRB(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt),
    .sub_rdt(fp_sub_rdt), .sub_err(fp_sub_err), .sub_rdy(fp_sub_rdy),
    .man_vld(fp_man_vld), .man_wen(fp_man_wen), .man_adr(fp_man_adr), .man_ben(fp_man_ben),
    .man_wdt(fp_man_wdt), .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy),
    .gnt(fp_gnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: config 0 = round-robin, 1 = fixed priority.
  int m_last [2];
  bit m_hold [2];
  int m_hix  [2];
  int rsp [int];   // key = due_cycle*2 + config, value = manager index
  int cyc = 0;

  function automatic int pick(input int c, input logic [MPN-1:0] v);
    int m;
    if (m_hold[c]) return v[m_hix[c]] ? m_hix[c] : -1;
    for (int s = 1; s <= MPN; s++) begin
      m = (c == 0) ? (m_last[c] + s) % MPN : s - 1;
      if (v[m]) return m;
    end
    return -1;
  endfunction

  task automatic cmp_cfg(input int c, input logic [MPN-1:0] g, input logic [MPN-1:0] rdy,
                         input logic [MPN-1:0] err, input logic mv, input logic mw,
                         input logic [ADR-1:0] ma, input logic [BEN-1:0] mb,
                         input logic [DAT-1:0] mwd, input logic [MPN*DAT-1:0] rdt);
    int w;
    int key;
    logic [MPN-1:0] eg, eerr;
    string p;
    p  = (c == 0) ? "rr" : "fp";
    w  = pick(c, sub_vld);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check({p, "_gnt"}, 64'(g), 64'(eg));
    check({p, "_sub_rdy"}, 64'(rdy), man_rdy ? 64'(eg) : 64'd0);
    check({p, "_man_vld"}, 64'(mv), (w >= 0) ? 64'd1 : 64'd0);
    if (w >= 0) begin
      check({p, "_man_wen"}, 64'(mw), 64'(sub_wen[w]));
      check({p, "_man_adr"}, 64'(ma), 64'(sub_adr[w*ADR +: ADR]));
      check({p, "_man_ben"}, 64'(mb), 64'(sub_ben[w*BEN +: BEN]));
      check({p, "_man_wdt"}, 64'(mwd), 64'(sub_wdt[w*DAT +: DAT]));
    end
    eerr = '0;
    key  = cyc*2 + c;
    if (rsp.exists(key)) eerr[rsp[key]] = man_err;
    check({p, "_sub_err"}, 64'(err), 64'(eerr));
    check({p, "_sub_rdt"}, rdt, {man_rdt, man_rdt});
    if (!rst && w >= 0) begin
      if (man_rdy) begin
        m_last[c] = w;
        m_hold[c] = 1'b0;
        rsp[(cyc + DLY)*2 + c] = w;
      end else begin
        m_hold[c] = 1'b1;
        m_hix[c]  = w;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_last = '{MPN-1, MPN-1};
      m_hold = '{1'b0, 1'b0};
      m_hix  = '{0, 0};
      rsp.delete();
    end
    cmp_cfg(0, rr_gnt, rr_sub_rdy, rr_sub_err, rr_man_vld, rr_man_wen, rr_man_adr,
            rr_man_ben, rr_man_wdt, rr_sub_rdt);
    cmp_cfg(1, fp_gnt, fp_sub_rdy, fp_sub_err, fp_man_vld, fp_man_wen, fp_man_adr,
            fp_man_ben, fp_man_wdt, fp_sub_rdt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    sub_vld = '0;
    sub_wen = '0;
    sub_adr = {32'h0000_0200, 32'h0000_0100};
    sub_ben = {4'hC, 4'h3};
    sub_wdt = {32'hBBBB_0001, 32'hAAAA_0000};
    man_rdt = 32'h1234_5678;
    man_err = 1'b0;
    man_rdy = 1'b1;

    neg();
    check("rst_gnt", 64'(rr_gnt), 64'd0);
    check("rst_sub_err", 64'(rr_sub_err), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Both managers requesting: round-robin alternates, fixed priority starves manager 1.
    sub_vld = 2'b11;
    for (int k = 0; k < 4; k++) begin
      neg();
      check("rr_seq_gnt", 64'(rr_gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_seq_adr", 64'(rr_man_adr), (k % 2 == 0) ? 64'h100 : 64'h200);
      check("fp_seq_gnt", 64'(fp_gnt), 64'd1);
      check("fp_seq_rdy1", 64'(fp_sub_rdy[1]), 64'd0);
      step();
    end
    sub_vld = 2'b00;
    neg();
    step();

    // Stalled grant held while the other manager requests.
    sub_vld = 2'b01;
    neg();
    check("pre_lock_gnt", 64'(rr_gnt), 64'd1);
    step();
    man_rdy = 1'b0;
    neg();
    check("stall_gnt", 64'(rr_gnt), 64'd1);
    check("stall_rdy", 64'(rr_sub_rdy), 64'd0);
    step();
    sub_vld = 2'b11;
    for (int k = 0; k < 2; k++) begin
      neg();
      check("lock_gnt", 64'(rr_gnt), 64'd1);
      check("lock_rdy", 64'(rr_sub_rdy), 64'd0);
      step();
    end
    man_rdy = 1'b1;
    neg();
    check("unlock_gnt", 64'(rr_gnt), 64'd1);
    check("unlock_rdy", 64'(rr_sub_rdy), 64'd1);
    step();
    neg();
    check("post_lock_gnt", 64'(rr_gnt), 64'd2);
    step();

    // Read by manager 1 with an error response one cycle later.
    sub_vld = 2'b10;
    sub_wen = 2'b00;
    sub_adr[63:32] = 32'h0000_0010;
    neg();
    check("rd_gnt", 64'(rr_gnt), 64'd2);
    check("rd_adr", 64'(rr_man_adr), 64'h10);
    step();
    sub_vld = 2'b00;
    man_rdt = 32'hDEAD_BEEF;
    man_err = 1'b1;
    neg();
    check("rd_err", 64'(rr_sub_err), 64'd2);
    check("rd_rdt1", 64'(rr_sub_rdt[63:32]), 64'hDEAD_BEEF);
    step();
    man_err = 1'b0;

    // Back-to-back write (manager 0) then read (manager 1); error only on the second response.
    sub_vld = 2'b01;
    sub_wen = 2'b01;
    neg();
    check("b2b_wen", 64'(rr_man_wen), 64'd1);
    step();
    sub_vld = 2'b10;
    sub_wen = 2'b00;
    man_err = 1'b0;
    neg();
    check("b2b_gnt1", 64'(rr_gnt), 64'd2);
    check("b2b_err0", 64'(rr_sub_err), 64'd0);
    step();
    sub_vld = 2'b00;
    man_err = 1'b1;
    neg();
    check("b2b_err1", 64'(rr_sub_err), 64'd2);
    step();
    man_err = 1'b0;

    // Reset one cycle after a transfer discards its response.
    sub_vld = 2'b01;
    neg();
    step();
    rst     = 1'b1;
    sub_vld = 2'b00;
    man_err = 1'b1;
    neg();
    check("rst_drop_err_rr", 64'(rr_sub_err), 64'd0);
    check("rst_drop_err_fp", 64'(fp_sub_err), 64'd0);
    step();
    rst     = 1'b0;
    man_err = 1'b0;
    sub_vld = 2'b11;
    neg();
    check("rst_first_gnt", 64'(rr_gnt), 64'd1);
    step();

    // Reset while a grant is held drops the hold.
    sub_vld = 2'b01;
    man_rdy = 1'b0;
    neg();
    step();
    rst     = 1'b1;
    sub_vld = 2'b00;
    neg();
    step();
    rst     = 1'b0;
    sub_vld = 2'b10;
    neg();
    check("lock_drop_gnt", 64'(rr_gnt), 64'd2);
    check("lock_drop_vld", 64'(rr_man_vld), 64'd1);
    step();
    man_rdy = 1'b1;
    sub_vld = 2'b00;
    neg();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tcb_lib_arbiter.md
Name:
tcb_lib_arbiter

Overview:
- Round-robin arbiter that shares one TCB subordinate (typically the SoC shared memory, DLY=1) between MPN TCB managers, e.g. the CPU load/store path and a debug/DMA manager.
- Sits between the managers' TCB buses and the memory-side bus.
- Sequences request grants, holds a grant across back-pressure, and routes each response back to the manager that issued the request DLY cycles earlier.

Parameters:
- MPN, 2, number of managers (≥2).
- ADR, 32, address width.
- DAT, 32, data width.
- BEN, DAT/8, byte-enable width.
- DLY, 1, response delay of the subordinate in cycles (≥0).
- RRB, 1'b1, 1 = round-robin priority, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sub_vld  in  MPN  request valid per manager
- sub_wen  in  MPN  write enable per manager
- sub_adr  in  MPN*ADR  address, manager i at [i*ADR +: ADR]
- sub_ben  in  MPN*BEN  byte enables
- sub_wdt  in  MPN*DAT  write data
- sub_rdt  out  MPN*DAT  read data
- sub_err  out  MPN  response error
- sub_rdy  out  MPN  ready per manager
- man_vld  out  1  request valid to subordinate
- man_wen  out  1  write enable
- man_adr  out  ADR  address
- man_ben  out  BEN  byte enables
- man_wdt  out  DAT  write data
- man_rdt  in  DAT  read data from subordinate
- man_err  in  1  error from subordinate
- man_rdy  in  1  ready from subordinate
- gnt  out  MPN  one-hot current grant (status/debug)

Behaviour:
- Clock/reset: single clock domain `clk`; `rst` is asynchronous and active-high.
- Transfer definition: man_vld & man_rdy. Response appears on man_rdt/man_err exactly DLY cycles after the transfer.

Arbitration:
- Arbitration is combinational over sub_vld using registered pointer `ptr` (index of last served manager).
- RRB=1: search starts at ptr+1 modulo MPN and wraps.
- RRB=0: lowest asserted index wins; ptr is ignored.

Grant hold (register `lck` + `lix`):
- If the granted manager's request is not accepted (man_vld & ~man_rdy), set lck=1 and lix=granted index.
- While lck=1, the grant is forced to lix regardless of other sub_vld.
- lck clears on the transfer cycle.
- TCB requires the request to stay stable until rdy; the arbiter relies on this.

Muxing:
- man_* request fields = fields of the granted manager.
- man_vld = |sub_vld (or sub_vld[lix] when lck).
- gnt = one-hot grant; all zero when no sub_vld.

Ready:
- sub_rdy[i] = man_rdy & gnt[i].
- Non-granted managers see 0.

Pointer update:
- On each transfer, ptr <= granted index.
- No update without a transfer.

Response routing:
- Shift register of depth DLY carries {valid, index}; a transfer pushes {1, index}.
- At the output stage, when valid=1: sub_err[index] = man_err and all other sub_err = 0.
- sub_rdt is broadcast: sub_rdt[i] = man_rdt for all i. Managers qualify it with their own outstanding state.
- DLY=0: routing uses the current grant directly.

Back-to-back operation:
- Transfers from different managers in consecutive cycles are supported, with one transfer per cycle at full throughput.

Reset:
- ptr=MPN-1, so manager 0 has first priority after reset.
- lck=0, lix=0.
- Response pipeline valid bits = 0, so sub_err = 0.
- gnt follows sub_vld (combinational).

Reset mid-operation:
- In-flight responses are discarded; no sub_err is routed after reset.
- Lock is dropped.

Simultaneous events:
- A request arriving in the same cycle a locked transfer completes is arbitrated next cycle with the updated ptr.

Test Plan:
- After reset, sub_vld=2'b11, man_rdy=1 for 4 cycles → grants 0,1,0,1; man_adr alternates sub_adr[0]/sub_adr[1]; ptr ends at 1.
- Manager 0 granted with man_rdy=0 for 3 cycles while manager 1 asserts vld → gnt stays 2'b01 and sub_rdy[1]=0 throughout; on the man_rdy=1 cycle manager 0 transfers, and the next cycle grants manager 1.
- Read 0x0000_0010 from manager 1 with DLY=1, man_rdt=0xDEAD_BEEF and man_err=1 one cycle later → sub_err=2'b10; sub_rdt[1]=0xDEAD_BEEF.
- Back-to-back write by manager 0 then read by manager 1, with the subordinate returning err only on the second response → sub_err[0]=0 in cycle T+1, sub_err[1]=1 in cycle T+2.
- RRB=0 with sub_vld=2'b11 held for 3 cycles → manager 0 is granted every cycle; sub_rdy[1]=0.
- Assert rst one cycle after a transfer (before its response) → no sub_err pulse after reset; the next arbitration with sub_vld=2'b11 grants manager 0.
